// File: rtl/fp_adder_arbiter.sv
// Round-robin arbiter sharing one floating-point adder among NUM_REQ requesters.
// A per-job watchdog aborts a stalled job with a quiet-NaN error response.
module fp_adder_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [64*NUM_REQ-1:0]  req_a,
  input  logic [64*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [63:0]            rsp_sum,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic [63:0]            fpa_A,
  output logic [63:0]            fpa_B,
  output logic                   fpa_A_store_bit,
  output logic                   fpa_B_store_bit,
  input  logic                   fpa_A_acknowledgment,
  input  logic                   fpa_B_acknowledgment,
  input  logic                   fpa_SUM_store_bit,
  input  logic [63:0]            fpa_SUM
);

  localparam int unsigned   DW       = 64;
  localparam int unsigned   IW       = 3;
  localparam int unsigned   CW       = 16;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic          WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [DW-1:0] QNAN     = 64'hFFF8_0000_0000_0000;

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_SUM, RESPOND} state_t;

  state_t             state, state_d;
  logic [IW-1:0]      rr_ptr, rr_d, gid_d, pick;
  logic [IW:0]        cand;
  logic               found, timeout, abort;
  logic [NUM_REQ-1:0] req_sh, rdy_sh, gnt_oh, ack_d, vld_d;
  logic [DW-1:0]      a_sel, b_sel, a_d, b_d, sum_d;
  logic               sa_d, sb_d, err_d, busy_d;
  logic [CW-1:0]      cnt, cnt_d;

  // First requesting index at or above rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    cand   = '0;
    req_sh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (IW+1)'(rr_ptr) + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      req_sh = req >> cand;
      if (!found && req_sh[0]) begin
        found = 1'b1;
        pick  = IW'(cand);
      end
    end
  end

  assign a_sel   = DW'(req_a >> (32'(pick) * DW));
  assign b_sel   = DW'(req_b >> (32'(pick) * DW));
  assign gnt_oh  = NUM_REQ'(1) << grant_id;
  assign rdy_sh  = rsp_ready >> grant_id;
  assign timeout = WD_EN && (cnt == CNT_LAST);

  always_comb begin
    state_d = state;
    rr_d    = rr_ptr;
    gid_d   = grant_id;
    a_d     = fpa_A;
    b_d     = fpa_B;
    sa_d    = fpa_A_store_bit;
    sb_d    = fpa_B_store_bit;
    ack_d   = '0;
    vld_d   = rsp_valid;
    sum_d   = rsp_sum;
    err_d   = rsp_err;
    cnt_d   = cnt;
    abort   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          a_d     = a_sel;
          b_d     = b_sel;
          gid_d   = pick;
          rr_d    = (pick == IW'(NUM_REQ - 1)) ? '0 : pick + IW'(1);
          cnt_d   = '0;
          sa_d    = 1'b1;
          ack_d   = NUM_REQ'(1) << pick;
          state_d = SEND_A;
        end
      end
      SEND_A: begin
        cnt_d = cnt + CW'(1);
        if (fpa_A_store_bit && fpa_A_acknowledgment) begin
          sa_d    = 1'b0;
          sb_d    = 1'b1;
          state_d = SEND_B;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      SEND_B: begin
        cnt_d = cnt + CW'(1);
        if (fpa_B_store_bit && fpa_B_acknowledgment) begin
          sb_d    = 1'b0;
          state_d = WAIT_SUM;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      WAIT_SUM: begin
        cnt_d = cnt + CW'(1);
        if (fpa_SUM_store_bit) begin
          sum_d   = fpa_SUM;
          err_d   = 1'b0;
          vld_d   = gnt_oh;
          state_d = RESPOND;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      RESPOND: begin
        if (rdy_sh[0]) begin
          vld_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Watchdog abort: release the adder and answer with the NaN error pattern
    if (abort) begin
      sa_d    = 1'b0;
      sb_d    = 1'b0;
      sum_d   = QNAN;
      err_d   = 1'b1;
      vld_d   = gnt_oh;
      state_d = RESPOND;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      grant_id        <= '0;
      fpa_A           <= '0;
      fpa_B           <= '0;
      fpa_A_store_bit <= 1'b0;
      fpa_B_store_bit <= 1'b0;
      req_ack         <= '0;
      rsp_valid       <= '0;
      rsp_sum         <= '0;
      rsp_err         <= 1'b0;
      cnt             <= '0;
      busy            <= 1'b0;
    end else begin
      state           <= state_d;
      rr_ptr          <= rr_d;
      grant_id        <= gid_d;
      fpa_A           <= a_d;
      fpa_B           <= b_d;
      fpa_A_store_bit <= sa_d;
      fpa_B_store_bit <= sb_d;
      req_ack         <= ack_d;
      rsp_valid       <= vld_d;
      rsp_sum         <= sum_d;
      rsp_err         <= err_d;
      cnt             <= cnt_d;
      busy            <= busy_d;
    end
  end

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Randomized bench for fp_adder_arbiter: a transaction-level round-robin and
// floating-point reference, plus a second instance with a short watchdog.
module tb_fp_adder_arbiter;

  localparam int unsigned N    = 4;
  localparam logic [63:0] QNAN = 64'hFFF8_0000_0000_0000;

  logic            Clock = 1'b0;
  logic            Reset;
  logic [N-1:0]    req, req_ack, rsp_valid, rsp_ready;
  logic [64*N-1:0] req_a, req_b;
  logic [63:0]     rsp_sum, fpa_A, fpa_B, fpa_SUM;
  logic            rsp_err, busy, fpa_A_store_bit, fpa_B_store_bit;
  logic [2:0]      grant_id;
  logic            a_ack_en, b_ack_en, sum_vld;

  logic [N-1:0]    wd_req, wd_ack, wd_valid, wd_rdy;
  logic [64*N-1:0] wd_a, wd_b;
  logic [63:0]     wd_sum, wd_fa, wd_fb;
  logic            wd_err, wd_busy, wd_sa, wd_sb;
  logic [2:0]      wd_gid;

  logic [63:0] op_a [N];
  logic [63:0] op_b [N];
  int          m_ptr;
  int          errors = 0;
  int          checks = 0;

  always #5 Clock = ~Clock;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[64*i +: 64] = op_a[i];
      req_b[64*i +: 64] = op_b[i];
    end
  end

  fp_adder_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(1024)) dut (
    .Clock(Clock), .Reset(Reset), .req(req), .req_a(req_a), .req_b(req_b),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_err(rsp_err), .busy(busy), .grant_id(grant_id),
    .fpa_A(fpa_A), .fpa_B(fpa_B), .fpa_A_store_bit(fpa_A_store_bit),
    .fpa_B_store_bit(fpa_B_store_bit), .fpa_A_acknowledgment(a_ack_en),
    .fpa_B_acknowledgment(b_ack_en), .fpa_SUM_store_bit(sum_vld), .fpa_SUM(fpa_SUM)
  );

  fp_adder_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut_wd (
    .Clock(Clock), .Reset(Reset), .req(wd_req), .req_a(wd_a), .req_b(wd_b),
    .req_ack(wd_ack), .rsp_valid(wd_valid), .rsp_ready(wd_rdy),
    .rsp_sum(wd_sum), .rsp_err(wd_err), .busy(wd_busy), .grant_id(wd_gid),
    .fpa_A(wd_fa), .fpa_B(wd_fb), .fpa_A_store_bit(wd_sa),
    .fpa_B_store_bit(wd_sb), .fpa_A_acknowledgment(1'b1),
    .fpa_B_acknowledgment(1'b1), .fpa_SUM_store_bit(1'b0), .fpa_SUM(64'd0)
  );

  function automatic logic [63:0] fadd(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) + $bitstoreal(b));
  endfunction

  function automatic logic [63:0] rand_op();
    return $realtobits(real'($urandom_range(0, 4000)) / 16.0 - 100.0);
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (p + k) % N;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  // Adder model: takes A and B on their handshakes, returns A+B after lat+1 cycles
  logic [63:0] a_q, b_q;
  int          lat, cnt_m;
  logic        run;
  always @(posedge Clock) begin
    if (!Reset) begin
      sum_vld <= 1'b0;
      run     <= 1'b0;
      fpa_SUM <= '0;
      cnt_m   <= 0;
    end else begin
      sum_vld <= 1'b0;
      if (fpa_A_store_bit && a_ack_en) a_q <= fpa_A;
      if (fpa_B_store_bit && b_ack_en) begin
        b_q   <= fpa_B;
        run   <= 1'b1;
        cnt_m <= lat;
      end else if (run) begin
        if (cnt_m == 0) begin
          run     <= 1'b0;
          sum_vld <= 1'b1;
          fpa_SUM <= fadd(a_q, b_q);
        end else begin
          cnt_m <= cnt_m - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    step();
    step();
    Reset = 1'b1;
    m_ptr = 0;
  endtask

  // Wait for the predicted grant and check the launched operands
  task automatic grant_phase(output int g, output logic [63:0] ea, output logic [63:0] eb);
    int n;
    g     = rr_pick(req, m_ptr);
    ea    = op_a[g];
    eb    = op_b[g];
    m_ptr = (g + 1) % N;
    n     = 0;
    while (req_ack == '0 && n < 20) begin
      step();
      n++;
    end
    check("ack_vec", 64'(req_ack), 64'(1) << g);
    check("grant_id", 64'(grant_id), 64'(g));
    check("fpa_A", fpa_A, ea);
    check("fpa_B", fpa_B, eb);
    check("busy_on", 64'(busy), 64'd1);
  endtask

  task automatic wait_rsp(input int g, input logic [63:0] es, input logic ee);
    int n;
    step();
    check("ack_pulse", 64'(req_ack), 64'd0);
    n = 0;
    while (rsp_valid == '0 && n < 300) begin
      step();
      n++;
    end
    check("rsp_valid", 64'(rsp_valid), 64'(1) << g);
    check("rsp_sum", rsp_sum, es);
    check("rsp_err", 64'(rsp_err), 64'(ee));
  endtask

  // Hold off the response (other ready bits asserted meanwhile), then accept it
  task automatic complete(input int g, input int delay);
    logic [63:0] s0;
    logic        e0;
    int          stable;
    s0     = rsp_sum;
    e0     = rsp_err;
    stable = 0;
    rsp_ready = ~(N'(1) << g);
    for (int k = 0; k < delay; k++) begin
      step();
      if (rsp_valid == (N'(1) << g) && rsp_sum == s0 && rsp_err == e0) stable++;
    end
    if (delay > 0) check("rsp_hold", 64'(stable), 64'(delay));
    rsp_ready = N'(1) << g;
    step();
    check("rsp_clear", 64'(rsp_valid), 64'd0);
    check("busy_off", 64'(busy), 64'd0);
    rsp_ready = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int          g, n, stable;
    logic [63:0] ea, eb, b0;

    Reset = 1'b0; req = '0; rsp_ready = '0; a_ack_en = 1'b1; b_ack_en = 1'b1;
    lat = 9; wd_req = '0; wd_rdy = '0; wd_a = '0; wd_b = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = rand_op();
      op_b[i] = rand_op();
    end
    step();
    step();
    check("rst_ctrl", 64'({req_ack, rsp_valid, rsp_err, busy, grant_id,
                           fpa_A_store_bit, fpa_B_store_bit}), 64'd0);
    check("rst_data", fpa_A | fpa_B | rsp_sum, 64'd0);
    Reset = 1'b1;
    m_ptr = 0;

    // Single job: 1.0 + 2.0
    op_a[1] = 64'h3FF0_0000_0000_0000;
    op_b[1] = 64'h4000_0000_0000_0000;
    req = 4'b0010;
    grant_phase(g, ea, eb);
    req = '0;
    wait_rsp(g, 64'h4008_0000_0000_0000, 1'b0);
    complete(g, 3);

    // Round robin with all requesters held from a fresh reset
    do_reset();
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      lat = $urandom_range(0, 6);
      grant_phase(g, ea, eb);
      check("rr_seq", 64'(grant_id), 64'(j % 4));
      op_a[g] = rand_op();
      op_b[g] = rand_op();
      wait_rsp(g, fadd(ea, eb), 1'b0);
      complete(g, $urandom_range(0, 2));
    end

    // Pointer skip: grant 2, then only 0 and 2 remain
    req = 4'b0100;
    grant_phase(g, ea, eb);
    req = 4'b0101;
    wait_rsp(g, fadd(ea, eb), 1'b0);
    complete(g, 0);
    for (int j = 0; j < 2; j++) begin
      grant_phase(g, ea, eb);
      check("skip_seq", 64'(grant_id), (j == 0) ? 64'd0 : 64'd2);
      wait_rsp(g, fadd(ea, eb), 1'b0);
      complete(g, 1);
    end
    req = '0;

    // B handshake stalled for 50 cycles
    b_ack_en = 1'b0;
    lat = 4;
    req = 4'b1000;
    grant_phase(g, ea, eb);
    req = '0;
    n = 0;
    while (!fpa_B_store_bit && n < 10) begin
      step();
      n++;
    end
    b0 = fpa_B;
    stable = 0;
    for (int k = 0; k < 50; k++) begin
      if (fpa_B_store_bit && !fpa_A_store_bit && fpa_B == b0 && b0 == eb) stable++;
      step();
    end
    check("b_stall_hold", 64'(stable), 64'd50);
    b_ack_en = 1'b1;
    wait_rsp(g, fadd(ea, eb), 1'b0);
    complete(g, 0);

    // Watchdog on the short-timeout instance; its adder never returns a sum
    wd_a = {4{rand_op()}};
    wd_b = {4{rand_op()}};
    wd_req = 4'b0100;
    n = 0;
    while (wd_ack == '0 && n < 10) begin
      step();
      n++;
    end
    check("wd_ack", 64'(wd_ack), 64'h4);
    wd_req = '0;
    n = 0;
    while (wd_valid == '0 && n < 40) begin
      step();
      n++;
    end
    check("wd_latency", 64'(n), 64'd16);
    check("wd_valid", 64'(wd_valid), 64'h4);
    check("wd_sum", wd_sum, QNAN);
    check("wd_err_stores", 64'({wd_err, wd_sa, wd_sb}), 64'b100);
    wd_rdy = 4'b0100;
    step();
    check("wd_busy_off", 64'({wd_busy, wd_valid}), 64'd0);
    wd_rdy = '0;

    // Randomized traffic
    for (int j = 0; j < 25; j++) begin
      lat = $urandom_range(0, 12);
      if (req == '0) req = N'($urandom_range(1, 15));
      grant_phase(g, ea, eb);
      op_a[g] = rand_op();
      op_b[g] = rand_op();
      req = req | N'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) req[g] = 1'b0;
      wait_rsp(g, fadd(ea, eb), 1'b0);
      complete(g, $urandom_range(0, 4));
    end

    // Backpressure for 20 cycles, then reset mid-RESPOND
    req = 4'b0010;
    grant_phase(g, ea, eb);
    req = 4'b1111;
    wait_rsp(g, fadd(ea, eb), 1'b0);
    b0 = rsp_sum;
    stable = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (rsp_valid == (N'(1) << g) && rsp_sum == b0) stable++;
    end
    check("bp_hold", 64'(stable), 64'd20);
    Reset = 1'b0;
    step();
    check("mid_rst_ctrl", 64'({req_ack, rsp_valid, rsp_err, busy, grant_id,
                               fpa_A_store_bit, fpa_B_store_bit}), 64'd0);
    check("mid_rst_data", fpa_A | fpa_B | rsp_sum, 64'd0);
    Reset = 1'b1;
    m_ptr = 0;
    grant_phase(g, ea, eb);
    check("post_rst_grant", 64'(grant_id), 64'd0);
    req = '0;
    wait_rsp(g, fadd(ea, eb), 1'b0);
    complete(g, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_adder_arbiter.md
Name: fp_adder_arbiter

Overview:
- Shares one Floating_Point_Adder instance between NUM_REQ requesters.
- Each requester presents an operand pair. The arbiter grants one job at a time in round-robin order.
- It drives the adder's A/B store handshakes, captures SUM, and returns it to the granted requester over a valid/ready response.
- A watchdog returns a quiet-NaN error response if the adder stalls.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 1024, per-job watchdog limit in cycles (1..65535); 0 disables the watchdog

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-low reset
req  in  NUM_REQ  per-requester job request (level)
req_a  in  64*NUM_REQ  operand A; requester i occupies bits [64i+63:64i]
req_b  in  64*NUM_REQ  operand B, same packing
req_ack  out  NUM_REQ  one-hot pulse: operands of requester i captured
rsp_valid  out  NUM_REQ  one-hot: response ready for requester i
rsp_ready  in  NUM_REQ  requester i accepts the response
rsp_sum  out  64  result value
rsp_err  out  1  1 = watchdog abort; rsp_sum is the NaN pattern
busy  out  1  1 whenever state != IDLE
grant_id  out  3  index of the current or last granted requester
fpa_A  out  64  operand A to adder
fpa_B  out  64  operand B to adder
fpa_A_store_bit  out  1  A-valid to adder
fpa_B_store_bit  out  1  B-valid to adder
fpa_A_acknowledgment  in  1  adder ready for A
fpa_B_acknowledgment  in  1  adder ready for B
fpa_SUM_store_bit  in  1  adder result valid
fpa_SUM  in  64  adder result

Behaviour:
- Reset (Reset==0 at a clock edge):
  - state=IDLE, rr_ptr=0, grant_id=0, timeout counter=0.
  - All outputs are 0, including fpa_A, fpa_B, rsp_sum and rsp_err.
  - Reset mid-job abandons the job silently: no response is issued and no requester is acknowledged.
  - The adder shares the same Reset net.
- All outputs are registered.
- States: IDLE, SEND_A, SEND_B, WAIT_SUM, RESPOND.
- IDLE:
  - If any req bit is high, select the first set bit searching upward from rr_ptr, modulo NUM_REQ. Call it g.
  - At that edge: latch req_a[g] into fpa_A and req_b[g] into fpa_B; set grant_id=g; set rr_ptr=(g+1) mod NUM_REQ; clear the counter; go to SEND_A.
  - req_ack[g] is high for exactly the first SEND_A cycle.
  - With no requests, IDLE holds and every output is unchanged.
- Requester obligations:
  - Hold req and operands until req_ack is seen.
  - req may stay high; the same requester cannot be re-granted before its response completes and the arbiter returns to IDLE.
- SEND_A:
  - fpa_A_store_bit=1.
  - A transfers on any cycle where fpa_A_store_bit && fpa_A_acknowledgment. On that edge, drop fpa_A_store_bit and go to SEND_B.
- SEND_B:
  - Same handshake, using fpa_B_store_bit and fpa_B_acknowledgment. On transfer, go to WAIT_SUM.
- WAIT_SUM:
  - On the first cycle with fpa_SUM_store_bit=1: rsp_sum<=fpa_SUM, rsp_err<=0, rsp_valid[grant_id]<=1, go to RESPOND.
  - fpa_SUM_store_bit is ignored in every other state.
- RESPOND:
  - Hold rsp_valid, rsp_sum and rsp_err stable until rsp_ready[grant_id]=1.
  - At that edge: clear rsp_valid, go to IDLE.
  - rsp_ready bits of other requesters are ignored.
  - No latency limit applies in RESPOND.
- Watchdog:
  - The 16-bit counter increments every cycle in SEND_A, SEND_B and WAIT_SUM.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without the awaited transfer: drop both store bits; rsp_sum<=64'hFFF8000000000000; rsp_err<=1; rsp_valid[grant_id]<=1; go to RESPOND.
  - If the transfer and the timeout fall on the same cycle, the transfer wins and the counter keeps running.
- Latency:
  - Best case from req high to rsp_valid is 4 cycles plus adder compute time.
  - There is a one-cycle IDLE bubble between consecutive jobs.
- Fairness: with all requesters continuously requesting, grants follow 0,1,2,3,0,...
- The arbiter never issues a new job while a response is pending.

Test Plan:
- Single job:
  - Stimulus: req[1]=1, A=0x3FF0000000000000, B=0x4000000000000000; adder model asserts acks and returns SUM=0x4008000000000000 10 cycles after B transfers.
  - Required: req_ack=4'b0010 one cycle; rsp_valid[1] with rsp_sum=0x4008000000000000, rsp_err=0; busy drops the cycle after rsp_ready[1].
- Round robin:
  - Stimulus: req=4'b1111 held.
  - Required: grant_id sequence 0,1,2,3,0; each req_ack one-hot; rsp_valid never asserted for two requesters at once.
- Pointer skip:
  - Stimulus: after granting 2, only req[0] and req[2] remain high.
  - Required: next grant is 0, then 2.
- Handshake stall:
  - Stimulus: adder holds fpa_B_acknowledgment=0 for 50 cycles (TIMEOUT_CYCLES=1024).
  - Required: fpa_B_store_bit and fpa_B held stable for all 50 cycles; normal completion afterwards.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=16; adder never asserts fpa_SUM_store_bit.
  - Required: rsp_valid for the granted requester with rsp_sum=0xFFF8000000000000, rsp_err=1, exactly 16 cycles after the counter clears.
- Backpressure and reset:
  - Stimulus: keep rsp_ready=0 for 20 cycles, then pull Reset low mid-RESPOND.
  - Required: rsp_valid and rsp_sum stable throughout the stall; after reset, all outputs 0, state IDLE, and the next grant goes to requester 0.
